// File: rtl/packet_forwarder.sv
// rtl/packet_forwarder.sv - drains a packet-memory buffer onto an AXI-Stream master port
module packet_forwarder #(
    parameter int FWD_DATA_WIDTH = 64,
    parameter int FWD_ADDR_WIDTH = 9,
    parameter int PLEN_WIDTH     = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        rdy_for_fwd,
    input  logic                        rdy_for_fwd_ack,
    input  logic [PLEN_WIDTH-1:0]       fwd_byte_len,
    output logic [FWD_ADDR_WIDTH-1:0]   fwd_addr,
    output logic                        fwd_rd_en,
    input  logic [FWD_DATA_WIDTH-1:0]   fwd_rd_data,
    output logic                        fwd_done,
    output logic [FWD_DATA_WIDTH-1:0]   fwd_TDATA,
    output logic [FWD_DATA_WIDTH/8-1:0] fwd_TKEEP,
    output logic                        fwd_TVALID,
    input  logic                        fwd_TREADY,
    output logic                        fwd_TLAST
);
    localparam int BYTES = FWD_DATA_WIDTH / 8;
    localparam int SH    = $clog2(BYTES);
    localparam int CW    = FWD_ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << FWD_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                    state_q, state_d;
    logic                      rdy_q, rdy_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [CW-1:0]             w_q, w_d;
    logic [BYTES-1:0]          keep_last_q, keep_last_d;
    logic                      pend_q, pend_d;
    logic                      pend_last_q, pend_last_d;
    logic                      o_valid_q, o_valid_d;
    logic [FWD_DATA_WIDTH-1:0] o_data_q, o_data_d;
    logic [BYTES-1:0]          o_keep_q, o_keep_d;
    logic                      o_last_q, o_last_d;
    logic                      s_valid_q, s_valid_d;
    logic [FWD_DATA_WIDTH-1:0] s_data_q, s_data_d;
    logic [BYTES-1:0]          s_keep_q, s_keep_d;
    logic                      s_last_q, s_last_d;

    logic [SH-1:0]             rem;
    logic [PLEN_WIDTH-1:0]     words;
    logic                      clamp;
    logic [CW-1:0]             w_new;
    logic [BYTES-1:0]          keep_new;
    logic                      hs;
    logic [1:0]                occ;
    logic                      issue;
    logic [BYTES-1:0]          in_keep;

    // Word count and final-beat byte mask derived from the offered packet length
    always_comb begin
        rem      = fwd_byte_len[SH-1:0];
        words    = (fwd_byte_len >> SH) + PLEN_WIDTH'(rem != '0);
        clamp    = words > PLEN_WIDTH'(DEPTH);
        w_new    = clamp ? CW'(DEPTH) : CW'(words);
        keep_new = '0;
        for (int b = 0; b < BYTES; b++) begin
            keep_new[b] = (b < int'(rem));
        end
        if (clamp || rem == '0) begin
            keep_new = '1;
        end
    end

    // Read issue, output/skid stage movement and packet state machine
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        w_d         = w_q;
        keep_last_d = keep_last_q;
        o_valid_d   = o_valid_q;
        o_data_d    = o_data_q;
        o_keep_d    = o_keep_q;
        o_last_d    = o_last_q;
        s_valid_d   = s_valid_q;
        s_data_d    = s_data_q;
        s_keep_d    = s_keep_q;
        s_last_d    = s_last_q;

        hs      = o_valid_q && fwd_TREADY;
        // Occupancy counts every word that will need a slot: both registers plus the read in flight.
        occ     = 2'(o_valid_q) + 2'(s_valid_q) + 2'(pend_q);
        issue   = (state_q == SEND) && (cnt_q < w_q) && ((occ - 2'(hs)) < 2'd2);
        in_keep = pend_last_q ? keep_last_q : '1;

        pend_d      = issue;
        pend_last_d = issue && (cnt_q == w_q - CW'(1));
        if (issue) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (!o_valid_q || hs) begin
            if (s_valid_q) begin
                o_valid_d = 1'b1;
                o_data_d  = s_data_q;
                o_keep_d  = s_keep_q;
                o_last_d  = s_last_q;
                s_valid_d = pend_q;
                if (pend_q) begin
                    s_data_d = fwd_rd_data;
                    s_keep_d = in_keep;
                    s_last_d = pend_last_q;
                end
            end else if (pend_q) begin
                o_valid_d = 1'b1;
                o_data_d  = fwd_rd_data;
                o_keep_d  = in_keep;
                o_last_d  = pend_last_q;
            end else begin
                o_valid_d = 1'b0;
                o_last_d  = 1'b0;
            end
        end else if (pend_q) begin
            s_valid_d = 1'b1;
            s_data_d  = fwd_rd_data;
            s_keep_d  = in_keep;
            s_last_d  = pend_last_q;
        end

        case (state_q)
            IDLE: begin
                if (rdy_q && rdy_for_fwd_ack) begin
                    w_d         = w_new;
                    keep_last_d = keep_new;
                    cnt_d       = '0;
                    state_d     = (w_new == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (hs && o_last_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rdy_d = (state_d == IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b0;
            cnt_q       <= '0;
            w_q         <= '0;
            keep_last_q <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            o_valid_q   <= 1'b0;
            o_data_q    <= '0;
            o_keep_q    <= '0;
            o_last_q    <= 1'b0;
            s_valid_q   <= 1'b0;
            s_data_q    <= '0;
            s_keep_q    <= '0;
            s_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            cnt_q       <= cnt_d;
            w_q         <= w_d;
            keep_last_q <= keep_last_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            o_valid_q   <= o_valid_d;
            o_data_q    <= o_data_d;
            o_keep_q    <= o_keep_d;
            o_last_q    <= o_last_d;
            s_valid_q   <= s_valid_d;
            s_data_q    <= s_data_d;
            s_keep_q    <= s_keep_d;
            s_last_q    <= s_last_d;
        end
    end

    assign rdy_for_fwd = rdy_q;
    assign fwd_done    = (state_q == DONE);
    assign fwd_rd_en   = issue;
    assign fwd_addr    = cnt_q[FWD_ADDR_WIDTH-1:0];
    assign fwd_TVALID  = o_valid_q;
    assign fwd_TDATA   = o_data_q;
    assign fwd_TKEEP   = o_keep_q;
    assign fwd_TLAST   = o_last_q;
endmodule

// File: tb/tb_packet_forwarder.sv
// tb/tb_packet_forwarder.sv - randomized self-checking bench for packet_forwarder
module tb_packet_forwarder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy_for_fwd;
    logic        rdy_for_fwd_ack = 1'b0;
    logic [31:0] fwd_byte_len = '0;
    logic [8:0]  fwd_addr;
    logic        fwd_rd_en;
    logic [63:0] fwd_rd_data = '0;
    logic        fwd_done;
    logic [63:0] fwd_TDATA;
    logic [7:0]  fwd_TKEEP;
    logic        fwd_TVALID;
    logic        fwd_TREADY = 1'b1;
    logic        fwd_TLAST;

    int checks = 0;
    int failures = 0;

    logic [63:0] mem [0:511];

    logic [63:0] q_data[$];
    logic [7:0]  q_keep[$];
    bit          q_last[$];
    int          q_cyc[$];
    int done_cyc, rdy_cyc, rd_cnt, max_out, unstable, addr_err, both_high, tvalid_seen;
    bit timed_out;

    packet_forwarder dut (
        .clk(clk), .rst(rst),
        .rdy_for_fwd(rdy_for_fwd), .rdy_for_fwd_ack(rdy_for_fwd_ack),
        .fwd_byte_len(fwd_byte_len), .fwd_addr(fwd_addr), .fwd_rd_en(fwd_rd_en),
        .fwd_rd_data(fwd_rd_data), .fwd_done(fwd_done),
        .fwd_TDATA(fwd_TDATA), .fwd_TKEEP(fwd_TKEEP), .fwd_TVALID(fwd_TVALID),
        .fwd_TREADY(fwd_TREADY), .fwd_TLAST(fwd_TLAST)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fwd_rd_en) fwd_rd_data <= mem[fwd_addr];
    end

    function automatic int exp_words(input int len);
        int w;
        w = (len + 7) / 8;
        if (w > 512) w = 512;
        return w;
    endfunction

    function automatic logic [7:0] exp_keep(input int len, input int i);
        int r;
        if (i < exp_words(len) - 1) return 8'hFF;
        r = len % 8;
        if (len > 4096 || r == 0) return 8'hFF;
        return 8'((1 << r) - 1);
    endfunction

    task automatic fill_mem(input bit ramp);
        for (int i = 0; i < 512; i++) mem[i] = ramp ? 64'(i) : {$urandom, $urandom};
    endtask

    // rmode 0: TREADY always 1; 1: random until cycle rnd_until then 1
    task automatic run_pkt(input int len, input int rmode, input int rnd_until,
                           input int budget, input int ack_at);
        int k, hs_cnt, w;
        bit stalled;
        logic [63:0] pd;
        logic [7:0]  pk;
        bit          pl;
        bit fin;
        q_data.delete(); q_keep.delete(); q_last.delete(); q_cyc.delete();
        done_cyc = -1; rdy_cyc = -1; rd_cnt = 0; max_out = 0; unstable = 0;
        addr_err = 0; both_high = 0; tvalid_seen = 0; timed_out = 0;
        hs_cnt = 0; stalled = 0; fin = 0; pd = '0; pk = '0; pl = 0;
        w = 0;
        while (!rdy_for_fwd && w < 10) begin
            @(posedge clk); #1; w++;
        end
        @(negedge clk);
        fwd_byte_len = 32'(len);
        rdy_for_fwd_ack = 1'b1;
        fwd_TREADY = 1'b1;
        @(posedge clk); #1;
        rdy_for_fwd_ack = 1'b0;
        k = 1;
        while (k <= budget && !fin) begin
            fwd_TREADY = (rmode == 1 && k < rnd_until) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (k == ack_at) begin
                rdy_for_fwd_ack = 1'b1;
                fwd_byte_len = 32'd24;
            end else begin
                rdy_for_fwd_ack = 1'b0;
            end
            @(negedge clk);
            if (fwd_rd_en) begin
                if (int'(fwd_addr) != rd_cnt) addr_err++;
                rd_cnt++;
            end
            if (fwd_TVALID) tvalid_seen++;
            if (fwd_TVALID && stalled &&
                (fwd_TDATA !== pd || fwd_TKEEP !== pk || fwd_TLAST !== pl)) unstable++;
            if (fwd_TVALID && fwd_TREADY) begin
                q_data.push_back(fwd_TDATA); q_keep.push_back(fwd_TKEEP);
                q_last.push_back(fwd_TLAST); q_cyc.push_back(k);
                hs_cnt++;
                stalled = 0;
            end else begin
                stalled = fwd_TVALID;
            end
            pd = fwd_TDATA; pk = fwd_TKEEP; pl = fwd_TLAST;
            if (rd_cnt - hs_cnt > max_out) max_out = rd_cnt - hs_cnt;
            if (fwd_done && rdy_for_fwd) both_high++;
            if (fwd_done && done_cyc < 0) done_cyc = k;
            if (rdy_for_fwd && done_cyc >= 0) begin
                rdy_cyc = k;
                fin = 1;
            end
            @(posedge clk); #1;
            k++;
        end
        rdy_for_fwd_ack = 1'b0;
        fwd_TREADY = 1'b1;
        if (!fin) timed_out = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rdy_for_fwd !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%0b exp=0", rdy_for_fwd); end
        checks++; if (fwd_rd_en !== 1'b0 || fwd_addr !== 9'd0 || fwd_done !== 1'b0) begin
            failures++; $display("FAIL reset_mem got rd_en=%0b addr=%0d done=%0b exp=0,0,0", fwd_rd_en, fwd_addr, fwd_done); end
        checks++; if (fwd_TVALID !== 1'b0 || fwd_TLAST !== 1'b0 || fwd_TKEEP !== 8'h00 || fwd_TDATA !== 64'h0) begin
            failures++; $display("FAIL reset_axis got v=%0b l=%0b k=%0h d=%0h exp=all zero", fwd_TVALID, fwd_TLAST, fwd_TKEEP, fwd_TDATA); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (rdy_for_fwd !== 1'b1) begin failures++; $display("FAIL reset_release_rdy got=%0b exp=1", rdy_for_fwd); end
    endtask

    task automatic test_full_rate();
        fill_mem(1);
        run_pkt(64, 0, 0, 40, -1);
        checks++; if (timed_out) begin failures++; $display("FAIL full_timeout got=timeout exp=done"); end
        checks++; if (q_data.size() != 8) begin failures++; $display("FAIL full_beats got=%0d exp=8", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 8; i++) begin
            checks++;
            if (q_data[i] !== 64'(i) || q_keep[i] !== 8'hFF || q_last[i] !== (i == 7) || q_cyc[i] != 3 + i) begin
                failures++;
                $display("FAIL full_beat%0d got d=%0h k=%0h l=%0b cyc=%0d exp d=%0h k=ff l=%0b cyc=%0d",
                         i, q_data[i], q_keep[i], q_last[i], q_cyc[i], i, (i == 7), 3 + i);
            end
        end
        checks++; if (done_cyc != 11) begin failures++; $display("FAIL full_done_cyc got=%0d exp=11", done_cyc); end
        checks++; if (rdy_cyc != 12) begin failures++; $display("FAIL full_rdy_cyc got=%0d exp=12", rdy_cyc); end
        checks++; if (both_high != 0) begin failures++; $display("FAIL full_done_rdy_overlap got=%0d exp=0", both_high); end
    endtask

    task automatic test_short();
        int lens[2] = '{13, 8};
        fill_mem(0);
        foreach (lens[n]) begin
            run_pkt(lens[n], 0, 0, 40, -1);
            checks++; if (q_data.size() != exp_words(lens[n])) begin
                failures++; $display("FAIL short%0d_beats got=%0d exp=%0d", lens[n], q_data.size(), exp_words(lens[n])); end
            for (int i = 0; i < q_data.size(); i++) begin
                checks++;
                if (q_data[i] !== mem[i] || q_keep[i] !== exp_keep(lens[n], i) ||
                    q_last[i] !== (i == exp_words(lens[n]) - 1)) begin
                    failures++;
                    $display("FAIL short%0d_beat%0d got d=%0h k=%0h l=%0b exp d=%0h k=%0h",
                             lens[n], i, q_data[i], q_keep[i], q_last[i], mem[i], exp_keep(lens[n], i));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int len, n;
        for (int it = 0; it < 5; it++) begin
            fill_mem(0);
            len = (it == 0) ? 64 : (it == 1) ? 200 : $urandom_range(1, 300);
            run_pkt(len, 1, (it == 1) ? 20 : 1000, 1200, -1);
            n = exp_words(len);
            checks++; if (timed_out || q_data.size() != n) begin
                failures++; $display("FAIL bp_len%0d_beats got=%0d timeout=%0b exp=%0d", len, q_data.size(), timed_out, n); end
            for (int i = 0; i < q_data.size(); i++) begin
                if (q_data[i] !== mem[i] || q_keep[i] !== exp_keep(len, i) || q_last[i] !== (i == n - 1)) begin
                    checks++; failures++;
                    $display("FAIL bp_len%0d_beat%0d got d=%0h k=%0h l=%0b exp d=%0h k=%0h",
                             len, i, q_data[i], q_keep[i], q_last[i], mem[i], exp_keep(len, i));
                end
            end
            checks++; if (unstable != 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
            checks++; if (max_out > 2) begin failures++; $display("FAIL bp_occupancy got=%0d exp<=2", max_out); end
            checks++; if (addr_err != 0 || rd_cnt != n) begin
                failures++; $display("FAIL bp_reads got cnt=%0d err=%0d exp cnt=%0d err=0", rd_cnt, addr_err, n); end
            if (it == 1 && q_cyc.size() >= 3) begin
                checks++;
                if (q_cyc[q_cyc.size()-1] - q_cyc[q_cyc.size()-3] != 2) begin
                    failures++; $display("FAIL bp_burst_rate got gap=%0d exp=2",
                                         q_cyc[q_cyc.size()-1] - q_cyc[q_cyc.size()-3]);
                end
            end
        end
    endtask

    task automatic test_zero_len();
        run_pkt(0, 0, 0, 20, -1);
        checks++; if (tvalid_seen != 0 || rd_cnt != 0) begin
            failures++; $display("FAIL zero_activity got tvalid=%0d reads=%0d exp=0,0", tvalid_seen, rd_cnt); end
        checks++; if (done_cyc != 1) begin failures++; $display("FAIL zero_done_cyc got=%0d exp=1", done_cyc); end
        checks++; if (rdy_cyc != 2) begin failures++; $display("FAIL zero_rdy_cyc got=%0d exp=2", rdy_cyc); end
    endtask

    task automatic test_mid_reset();
        int hs_cnt, k, saw_done;
        fill_mem(1);
        @(negedge clk);
        fwd_byte_len = 32'd64; rdy_for_fwd_ack = 1'b1; fwd_TREADY = 1'b1;
        @(posedge clk); #1;
        rdy_for_fwd_ack = 1'b0;
        hs_cnt = 0; k = 0;
        while (hs_cnt < 3 && k < 20) begin
            @(negedge clk);
            if (fwd_TVALID && fwd_TREADY) hs_cnt++;
            k++;
        end
        checks++; if (hs_cnt != 3) begin failures++; $display("FAIL midrst_reach_beat3 got=%0d exp=3", hs_cnt); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (fwd_TVALID !== 0 || fwd_TLAST !== 0 || fwd_TKEEP !== 0 || fwd_TDATA !== 0 ||
                      fwd_rd_en !== 0 || fwd_addr !== 0 || fwd_done !== 0 || rdy_for_fwd !== 0) begin
            failures++; $display("FAIL midrst_outputs got v=%0b d=%0h rd=%0b a=%0d done=%0b rdy=%0b exp=all zero",
                                 fwd_TVALID, fwd_TDATA, fwd_rd_en, fwd_addr, fwd_done, rdy_for_fwd);
        end
        rst = 1'b0;
        saw_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (fwd_done) saw_done++;
        end
        checks++; if (saw_done != 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", saw_done); end
        checks++; if (rdy_for_fwd !== 1'b1) begin failures++; $display("FAIL midrst_rdy got=%0b exp=1", rdy_for_fwd); end
        run_pkt(64, 0, 0, 40, -1);
        checks++; if (q_data.size() != 8) begin failures++; $display("FAIL midrst_resend_beats got=%0d exp=8", q_data.size()); end
        for (int i = 0; i < q_data.size(); i++) begin
            checks++; if (q_data[i] !== 64'(i)) begin
                failures++; $display("FAIL midrst_resend_beat%0d got=%0h exp=%0h", i, q_data[i], i); end
        end
    endtask

    task automatic test_ack_during_send();
        fill_mem(0);
        run_pkt(80, 0, 0, 60, 5);
        checks++; if (q_data.size() != 10 || done_cyc != 13) begin
            failures++; $display("FAIL ackbusy_beats got=%0d done=%0d exp=10,13", q_data.size(), done_cyc); end
        for (int i = 0; i < q_data.size(); i++) begin
            checks++; if (q_data[i] !== mem[i] || q_last[i] !== (i == 9)) begin
                failures++; $display("FAIL ackbusy_beat%0d got d=%0h l=%0b exp d=%0h", i, q_data[i], q_last[i], mem[i]); end
        end
    endtask

    task automatic test_clamp();
        int lens[2] = '{8192, 4097};
        fill_mem(0);
        foreach (lens[n]) begin
            run_pkt(lens[n], 0, 0, 700, -1);
            checks++; if (q_data.size() != 512 || rd_cnt != 512 || addr_err != 0) begin
                failures++; $display("FAIL clamp%0d_beats got=%0d reads=%0d aerr=%0d exp=512,512,0",
                                     lens[n], q_data.size(), rd_cnt, addr_err); end
            checks++; if (q_data.size() == 512 &&
                          (q_keep[511] !== 8'hFF || q_last[511] !== 1'b1 || q_data[511] !== mem[511])) begin
                failures++; $display("FAIL clamp%0d_last got k=%0h l=%0b d=%0h exp k=ff l=1 d=%0h",
                                     lens[n], q_keep[511], q_last[511], q_data[511], mem[511]); end
            checks++; if (done_cyc != 515) begin failures++; $display("FAIL clamp%0d_done got=%0d exp=515", lens[n], done_cyc); end
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_short();
        test_backpressure();
        test_zero_len();
        test_mid_reset();
        test_ack_during_send();
        test_clamp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
